// File: rtl/cayde_alu_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cayde_alu_arb (with cayde_pkg ALU opcode definitions)        |
// | Description : Round-robin arbiter sharing one cayde_alu among NUM_REQ      |
// |               requesters; registers the result and hands it back with a    |
// |               valid/ready handshake.                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package cayde_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op;
endpackage

module cayde_alu_arb #(
    parameter int NUM_REQ = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    input  cayde_pkg::alu_op [NUM_REQ-1:0]   req_op_i,
    input  logic [NUM_REQ-1:0][31:0]         req_a_i,
    input  logic [NUM_REQ-1:0][31:0]         req_b_i,
    output cayde_pkg::alu_op                 alu_op_o,
    output logic [31:0]                      alu_a_o,
    output logic [31:0]                      alu_b_o,
    input  logic [31:0]                      alu_res_i,
    output logic [NUM_REQ-1:0]               rsp_valid_o,
    output logic [31:0]                      rsp_data_o,
    input  logic [NUM_REQ-1:0]               rsp_ready_i,
    output logic                             busy_o
);

    localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_ptr_w:0]   c_num_req = (c_ptr_w + 1)'(NUM_REQ);
    localparam logic [c_ptr_w-1:0] c_last    = (c_ptr_w)'(NUM_REQ - 1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_resp = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_ptr_w-1:0] r_rr_ptr;
    logic [c_ptr_w-1:0] r_owner;
    logic [31:0]        r_rsp_data;

    logic [c_ptr_w-1:0] w_cand [NUM_REQ];
    logic               w_found;
    logic [c_ptr_w-1:0] w_gnt_idx;
    logic               w_can_issue;
    logic               w_grant;
    logic [c_ptr_w-1:0] w_ptr_nxt;

    // Candidate k is requester (rr_ptr + k) mod NUM_REQ; one conditional
    // subtract suffices since both terms are below NUM_REQ.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
        logic [c_ptr_w:0] w_sum;
        logic [c_ptr_w:0] w_wrap;
        assign w_sum     = {1'b0, r_rr_ptr} + (c_ptr_w + 1)'(k);
        assign w_wrap    = w_sum - c_num_req;
        assign w_cand[k] = (w_sum >= c_num_req) ? w_wrap[c_ptr_w-1:0] : w_sum[c_ptr_w-1:0];
    end

    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid_i[w_cand[k]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand[k];
            end
        end
    end

    assign w_grant   = w_can_issue && w_found;
    assign w_ptr_nxt = (w_gnt_idx == c_last) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_can_issue = 1'b0;
        busy_o      = 1'b0;
        rsp_valid_o = '0;
        case (r_state)
            c_st_idle: begin
                w_can_issue = 1'b1;
                if (w_found) begin
                    w_state_nxt = c_st_resp;
                end
            end
            c_st_resp: begin
                busy_o               = 1'b1;
                rsp_valid_o[r_owner] = 1'b1;
                // Only the owner's ready releases the held result.
                if (rsp_ready_i[r_owner]) begin
                    w_can_issue = 1'b1;
                    w_state_nxt = w_found ? c_st_resp : c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        alu_op_o    = cayde_pkg::ALU_ADD;
        alu_a_o     = '0;
        alu_b_o     = '0;
        if (w_grant) begin
            req_ready_o[w_gnt_idx] = 1'b1;
            alu_op_o               = req_op_i[w_gnt_idx];
            alu_a_o                = req_a_i[w_gnt_idx];
            alu_b_o                = req_b_i[w_gnt_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_rsp_data <= '0;
        end else if (w_grant) begin
            r_rr_ptr   <= w_ptr_nxt;
            r_owner    <= w_gnt_idx;
            r_rsp_data <= alu_res_i;
        end
    end

    assign rsp_data_o = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_cayde_alu_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cayde_alu_arb                                             |
// | Description : Directed self-checking bench for cayde_alu_arb (2 and 3 req) |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cayde_alu_arb;
    import cayde_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Two-requester instance
    logic [1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
    alu_op [1:0]       req_op;
    logic [1:0][31:0]  req_a, req_b;
    alu_op             alu_op_w;
    logic [31:0]       alu_a, alu_b, alu_res, rsp_data;
    logic              busy;

    // Three-requester instance
    logic [2:0]        req_valid3, req_ready3, rsp_valid3, rsp_ready3;
    alu_op [2:0]       req_op3;
    logic [2:0][31:0]  req_a3, req_b3;
    alu_op             alu_op3;
    logic [31:0]       alu_a3, alu_b3, alu_res3, rsp_data3;
    logic              busy3;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [31:0] alu_model(alu_op op, logic [31:0] a, logic [31:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            default: return 32'h0;
        endcase
    endfunction

    assign alu_res  = alu_model(alu_op_w, alu_a, alu_b);
    assign alu_res3 = alu_model(alu_op3, alu_a3, alu_b3);

    cayde_alu_arb #(.NUM_REQ(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
        .alu_op_o(alu_op_w), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_res_i(alu_res),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_ready_i(rsp_ready),
        .busy_o(busy)
    );

    cayde_alu_arb #(.NUM_REQ(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid3), .req_ready_o(req_ready3),
        .req_op_i(req_op3), .req_a_i(req_a3), .req_b_i(req_b3),
        .alu_op_o(alu_op3), .alu_a_o(alu_a3), .alu_b_o(alu_b3), .alu_res_i(alu_res3),
        .rsp_valid_o(rsp_valid3), .rsp_data_o(rsp_data3), .rsp_ready_i(rsp_ready3),
        .busy_o(busy3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0; rsp_ready = '0;
        req_valid3 = '0; rsp_ready3 = '0;
        tick();
        tick();
        #1;
        n_chk++; if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); else n_pass++;
        n_chk++; if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_chk++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b expected 00", req_ready); else n_pass++;
        n_chk++; if (alu_op_w !== ALU_ADD || alu_a !== 32'h0 || alu_b !== 32'h0)
            $display("FAIL reset_alu_idle: got op=%0d a=%h b=%h expected op=0 a=0 b=0", alu_op_w, alu_a, alu_b); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req_op[0] = ALU_ADD; req_a[0] = 32'd5; req_b[0] = 32'd7;
        req_valid = 2'b01; rsp_ready = 2'b11;
        #1;
        n_chk++; if (req_ready !== 2'b01) $display("FAIL single_req_ready: got %b expected 01", req_ready); else n_pass++;
        n_chk++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_op_w !== ALU_ADD)
            $display("FAIL single_alu_drive: got op=%0d a=%0d b=%0d expected op=0 a=5 b=7", alu_op_w, alu_a, alu_b); else n_pass++;
        tick();
        req_valid = 2'b00;
        n_chk++; if (rsp_valid !== 2'b01) $display("FAIL single_rsp_valid: got %b expected 01", rsp_valid); else n_pass++;
        n_chk++; if (rsp_data !== 32'd12) $display("FAIL single_rsp_data: got %0d expected 12", rsp_data); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", busy); else n_pass++;
        tick();
        n_chk++; if (rsp_valid !== 2'b00 || busy !== 1'b0)
            $display("FAIL single_idle: got rsp_valid=%b busy=%b expected 00 0", rsp_valid, busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_oh;
        logic [31:0] exp_d;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req_op[0] = ALU_ADD; req_a[0] = 32'd100; req_b[0] = 32'd1;
        req_op[1] = ALU_SUB; req_a[1] = 32'd50;  req_b[1] = 32'd8;
        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_oh = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_d  = (i % 2 == 0) ? 32'd101 : 32'd42;
            #1;
            n_chk++; if (req_ready !== exp_oh) $display("FAIL b2b_grant%0d: got %b expected %b", i, req_ready, exp_oh); else n_pass++;
            tick();
            n_chk++; if (rsp_valid !== exp_oh || rsp_data !== exp_d)
                $display("FAIL b2b_rsp%0d: got valid=%b data=%0d expected %b %0d", i, rsp_valid, rsp_data, exp_oh, exp_d); else n_pass++;
        end
        req_valid = 2'b00;
        tick();
        n_chk++; if (rsp_valid !== 2'b00) $display("FAIL b2b_drain: got %b expected 00", rsp_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        // rr_ptr is 0 here; only req1 asks so it wins
        req_op[1] = ALU_SUB; req_a[1] = 32'd3; req_b[1] = 32'd5;
        req_valid = 2'b10; rsp_ready = 2'b00;
        #1;
        n_chk++; if (req_ready !== 2'b10) $display("FAIL bp_grant: got %b expected 10", req_ready); else n_pass++;
        tick();
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (rsp_valid !== 2'b10 || rsp_data !== 32'hFFFF_FFFE)
                $display("FAIL bp_hold%0d: got valid=%b data=%h expected 10 fffffffe", i, rsp_valid, rsp_data); else n_pass++;
            n_chk++; if (req_ready !== 2'b00 || alu_a !== 32'h0 || alu_op_w !== ALU_ADD)
                $display("FAIL bp_nogrant%0d: got ready=%b a=%h op=%0d expected 00 0 0", i, req_ready, alu_a, alu_op_w); else n_pass++;
            tick();
        end
        rsp_ready = 2'b10;
        #1;
        n_chk++; if (req_ready !== 2'b01) $display("FAIL bp_release_grant: got %b expected 01", req_ready); else n_pass++;
        tick();
        n_chk++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd101)
            $display("FAIL bp_next_rsp: got valid=%b data=%0d expected 01 101", rsp_valid, rsp_data); else n_pass++;
    endtask

    task automatic test_wrong_ready();
        // owner is 0; ready from requester 1 must be ignored
        req_valid = 2'b11; rsp_ready = 2'b10;
        #1;
        n_chk++; if (req_ready !== 2'b00) $display("FAIL wrong_ready_grant: got %b expected 00", req_ready); else n_pass++;
        tick();
        n_chk++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd101 || busy !== 1'b1)
            $display("FAIL wrong_ready_hold: got valid=%b data=%0d busy=%b expected 01 101 1", rsp_valid, rsp_data, busy); else n_pass++;
        req_valid = 2'b00; rsp_ready = 2'b01;
        tick();
        n_chk++; if (rsp_valid !== 2'b00) $display("FAIL wrong_ready_release: got %b expected 00", rsp_valid); else n_pass++;
    endtask

    task automatic test_wrap3();
        req_op3[0] = ALU_XOR; req_a3[0] = 32'hF0; req_b3[0] = 32'hFF;
        req_op3[1] = ALU_OR;  req_a3[1] = 32'h1;  req_b3[1] = 32'h2;
        req_op3[2] = ALU_SUB; req_a3[2] = 32'd10; req_b3[2] = 32'd3;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        rsp_ready3 = 3'b111;
        req_valid3 = 3'b010;
        #1;
        n_chk++; if (req_ready3 !== 3'b010) $display("FAIL wrap_setup: got %b expected 010", req_ready3); else n_pass++;
        tick();
        req_valid3 = 3'b101;
        #1;
        n_chk++; if (req_ready3 !== 3'b100) $display("FAIL wrap_grant2: got %b expected 100", req_ready3); else n_pass++;
        tick();
        n_chk++; if (rsp_valid3 !== 3'b100 || rsp_data3 !== 32'd7)
            $display("FAIL wrap_rsp2: got valid=%b data=%0d expected 100 7", rsp_valid3, rsp_data3); else n_pass++;
        n_chk++; if (req_ready3 !== 3'b001) $display("FAIL wrap_grant0: got %b expected 001", req_ready3); else n_pass++;
        tick();
        n_chk++; if (rsp_valid3 !== 3'b001 || rsp_data3 !== 32'h0F)
            $display("FAIL wrap_rsp0: got valid=%b data=%h expected 001 0f", rsp_valid3, rsp_data3); else n_pass++;
        // pointer now 1: the scan 1,2,0 must pick req2 over req0
        n_chk++; if (req_ready3 !== 3'b100) $display("FAIL wrap_ptr1: got %b expected 100", req_ready3); else n_pass++;
        req_valid3 = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        // pointer is 0 after the previous reset; only req1 asks
        req_op[1] = ALU_AND; req_a[1] = 32'hFF; req_b[1] = 32'h3C;
        req_valid = 2'b10; rsp_ready = 2'b00;
        tick();
        req_valid = 2'b00;
        n_chk++; if (rsp_valid !== 2'b10 || rsp_data !== 32'h3C)
            $display("FAIL rstmid_pending: got valid=%b data=%h expected 10 3c", rsp_valid, rsp_data); else n_pass++;
        rst_n = 1'b0;
        tick();
        n_chk++; if (rsp_valid !== 2'b00 || rsp_data !== 32'h0 || busy !== 1'b0)
            $display("FAIL rstmid_clear: got valid=%b data=%h busy=%b expected 00 0 0", rsp_valid, rsp_data, busy); else n_pass++;
        rst_n = 1'b1;
        req_op[0] = ALU_ADD; req_a[0] = 32'd1; req_b[0] = 32'd2;
        req_valid = 2'b11; rsp_ready = 2'b11;
        #1;
        n_chk++; if (req_ready !== 2'b01) $display("FAIL rstmid_ptr0: got %b expected 01", req_ready); else n_pass++;
        tick();
        req_valid = 2'b00;
        n_chk++; if (rsp_valid !== 2'b01 || rsp_data !== 32'd3)
            $display("FAIL rstmid_rsp: got valid=%b data=%0d expected 01 3", rsp_valid, rsp_data); else n_pass++;
        tick();
    endtask

    initial begin
        req_op = '{ALU_ADD, ALU_ADD}; req_a = '0; req_b = '0;
        req_op3 = '{ALU_ADD, ALU_ADD, ALU_ADD}; req_a3 = '0; req_b3 = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wrong_ready();
        test_wrap3();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
